// File: rtl/status_pager.sv
// rtl/status_pager.sv - multiplexes packed status pages onto the seven-segment bus with timed overlays
// Optional build macro STATUS_PAGER_BLINK_EN blanks the overlay page on alternate counter phases.
module status_pager #(
    parameter int          DIGITS    = 8,
    parameter int          PAGES     = 4,
    parameter int          DIV       = 29,
    parameter logic [5:0]  BLANK     = 6'h1D,
    parameter int          BLINK_BIT = 24
) (
    input  logic                         clk,
    input  logic                         mb_reset,
    input  logic [PAGES*DIGITS*6-1:0]    page_data,
    input  logic [$clog2(PAGES)-1:0]     base_page,
    input  logic [PAGES-1:0]             page_trigger,
    input  logic                         dismiss,
    output logic [DIGITS*6-1:0]          display,
    output logic [$clog2(PAGES)-1:0]     active_page,
    output logic                         overlay_active
);
    localparam int PW = $clog2(PAGES);
    localparam int DW = DIGITS * 6;

    if (PAGES < 2) begin : g_bad_pages
        $error("status_pager: PAGES must be at least 2");
    end
    if (BLINK_BIT >= DIV) begin : g_bad_blink
        $error("status_pager: BLINK_BIT must be below DIV");
    end

    logic [DIV-1:0] cnt_q, cnt_d;
    logic [PW-1:0]  ovl_page_q, ovl_page_d;
    logic [PW-1:0]  active_page_q, active_page_d;
    logic [DW-1:0]  display_q, display_d;
    logic           overlay_active_q, overlay_active_d;

    logic [PW-1:0]  winner;
    logic           trig_any;
    logic [PW-1:0]  base_sel;

    always_comb begin
        winner = '0;
        for (int p = PAGES - 1; p >= 0; p--) begin
            if (page_trigger[p]) winner = PW'(p);
        end
        trig_any = |page_trigger;

        // Trigger outranks dismiss; decrement only from a non-zero count so it never wraps.
        if (trig_any)
            cnt_d = '1;
        else if (dismiss)
            cnt_d = '0;
        else if (cnt_q != '0)
            cnt_d = cnt_q - DIV'(1);
        else
            cnt_d = cnt_q;

        ovl_page_d = trig_any ? winner : ovl_page_q;
        base_sel   = ({1'b0, base_page} >= (PW+1)'(PAGES)) ? '0 : base_page;

        overlay_active_d = |cnt_d;
        active_page_d    = overlay_active_d ? ovl_page_d : base_sel;

        display_d = {DIGITS{BLANK}};
        for (int p = 0; p < PAGES; p++) begin
            if (active_page_d == PW'(p)) display_d = page_data[p*DW +: DW];
        end
`ifdef STATUS_PAGER_BLINK_EN
        if (overlay_active_d && !cnt_d[BLINK_BIT]) display_d = {DIGITS{BLANK}};
`endif
    end

    always_ff @(posedge clk) begin
        if (mb_reset) begin
            cnt_q            <= '0;
            ovl_page_q       <= '0;
            active_page_q    <= '0;
            display_q        <= {DIGITS{BLANK}};
            overlay_active_q <= 1'b0;
        end else begin
            cnt_q            <= cnt_d;
            ovl_page_q       <= ovl_page_d;
            active_page_q    <= active_page_d;
            display_q        <= display_d;
            overlay_active_q <= overlay_active_d;
        end
    end

    assign display        = display_q;
    assign active_page    = active_page_q;
    assign overlay_active = overlay_active_q;
endmodule
